// File: rtl/matrix_op_seq.sv
// matrix_op_seq
//   Loads one or two SIZE x SIZE operand matrices element by element
//   (row-major), then streams out A+B, A-B or transpose(A), one element
//   per handshake.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin an operation (honoured only in IDLE)
//   op         0 add, 1 subtract, 2 transpose, 3 illegal (sampled with start)
//   in_data    operand element, in_valid / in_ready handshake
//   out_data   result element, out_valid / out_ready handshake (0 when idle)
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   err        one-cycle illegal-op pulse, coincident with done
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_A | accepting operand A elements
// LOAD_B | accepting operand B elements (add/subtract only)
// STREAM | presenting result elements
module matrix_op_seq #(
    parameter int SIZE   = 2,
    parameter int LENGTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [LENGTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LENGTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int N  = SIZE * SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_op,    w_op_nxt;
    logic [IW-1:0]     r_idx,   w_idx_nxt;
    logic [IW-1:0]     r_k,     w_k_nxt;
    logic              r_done,  w_done_nxt;
    logic              r_err,   w_err_nxt;

    logic [LENGTH-1:0] r_a [N];
    logic [LENGTH-1:0] r_b [N];

    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_last_idx;
    logic              w_last_k;
    logic [IW-1:0]     w_t_idx;
    logic [LENGTH-1:0] w_result;

    assign in_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign out_valid = (r_state == STREAM);
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err       = r_err;

    assign w_in_hs    = in_valid & in_ready;
    assign w_out_hs   = out_valid & out_ready;
    assign w_last_idx = (r_idx == IW'(N - 1));
    assign w_last_k   = (r_k == IW'(N - 1));

    // Output k (row k/SIZE, col k%SIZE) of the transpose reads A at (col, row).
    assign w_t_idx = IW'((int'(r_k) % SIZE) * SIZE + int'(r_k) / SIZE);

    always_comb begin
        w_result = '0;
        case (r_op)
            2'd0:    w_result = r_a[r_k] + r_b[r_k];
            2'd1:    w_result = r_a[r_k] - r_b[r_k];
            default: w_result = r_a[w_t_idx];
        endcase
    end

    assign out_data = out_valid ? w_result : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_idx_nxt   = r_idx;
        w_k_nxt     = r_k;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (op == 2'd3) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else begin
                        w_op_nxt    = op;
                        w_idx_nxt   = '0;
                        w_k_nxt     = '0;
                        w_state_nxt = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                if (w_in_hs) begin
                    if (w_last_idx) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (r_op == 2'd2) ? STREAM : LOAD_B;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (w_in_hs) begin
                    if (w_last_idx) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = STREAM;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (w_out_hs) begin
                    if (w_last_k) begin
                        w_k_nxt     = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= 2'd0;
            r_idx   <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_idx   <= w_idx_nxt;
            r_k     <= w_k_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Operand storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            if (r_state == LOAD_A) begin
                r_a[r_idx] <= in_data;
            end else begin
                r_b[r_idx] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_op_seq.sv
// tb_matrix_op_seq
//   Directed and randomized runs of matrix_op_seq (SIZE=2, LENGTH=8),
//   checked against a matrix-level reference model.
module tb_matrix_op_seq;

    localparam int SIZE   = 2;
    localparam int LENGTH = 8;
    localparam int N      = SIZE * SIZE;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        op = 2'd0;
    logic [LENGTH-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [LENGTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;

    logic [LENGTH-1:0] va    [N];
    logic [LENGTH-1:0] vb    [N];
    logic [LENGTH-1:0] exp_q [N];

    matrix_op_seq #(.SIZE(SIZE), .LENGTH(LENGTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Reference: treat operands as SIZE x SIZE matrices.
    function automatic void model(input logic [1:0] o);
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                case (o)
                    2'd0:    exp_q[r*SIZE+c] = va[r*SIZE+c] + vb[r*SIZE+c];
                    2'd1:    exp_q[r*SIZE+c] = va[r*SIZE+c] - vb[r*SIZE+c];
                    default: exp_q[r*SIZE+c] = va[c*SIZE+r];
                endcase
            end
        end
    endfunction

    task automatic rand_operands();
        for (int i = 0; i < N; i++) begin
            va[i] = LENGTH'($urandom);
            vb[i] = LENGTH'($urandom);
        end
    endtask

    // mode 0: continuous valid/ready; 1: random gaps/stalls plus junk start/op;
    // 2: in_valid gaps every other cycle and out_ready low for 3 stream cycles.
    // Called and left at a falling edge.
    task automatic run_op(input logic [1:0] o, input int mode);
        int  i;
        int  k;
        int  cyc;
        int  tot;
        logic v;
        logic r;
        start = 1'b1;
        op    = o;
        @(negedge clk);
        start = 1'b0;
        if (o == 2'd3) begin
            chk("ill_done",  32'(done), 32'd1);
            chk("ill_err",   32'(err), 32'd1);
            chk("ill_busy",  32'(busy), 32'd0);
            chk("ill_rdy",   32'(in_ready), 32'd0);
            @(negedge clk);
            chk("ill_done2", 32'(done), 32'd0);
            chk("ill_err2",  32'(err), 32'd0);
            chk("ill_busy2", 32'(busy), 32'd0);
            return;
        end
        chk("start_done", 32'(done), 32'd0);
        chk("start_err",  32'(err), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        model(o);
        tot = (o == 2'd2) ? N : 2 * N;
        i   = 0;
        cyc = 0;
        while (i < tot && cyc < 200) begin
            chk("in_ready",  32'(in_ready), 32'd1);
            chk("oval_load", 32'(out_valid), 32'd0);
            chk("odat_load", 32'(out_data), 32'd0);
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = 1'($urandom);
            else                v = (cyc % 2 == 0);
            in_valid = v;
            if (v) in_data = (i < N) ? va[i] : vb[i-N];
            else   in_data = LENGTH'($urandom);
            if (mode != 0) begin
                start = 1'($urandom);
                op    = 2'($urandom);
            end
            if (v) i++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) begin
            total++;
            bad++;
            $display("FAIL load_timeout got=%0d want=%0d", i, tot);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 200) begin
            chk("oval",      32'(out_valid), 32'd1);
            chk("odata",     32'(out_data), 32'(exp_q[k]));
            chk("rdy_strm",  32'(in_ready), 32'd0);
            chk("busy_strm", 32'(busy), 32'd1);
            chk("done_strm", 32'(done), 32'd0);
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = 1'($urandom);
            else                r = !(cyc >= 1 && cyc <= 3);
            out_ready = r;
            if (mode != 0) begin
                start = 1'($urandom);
                op    = 2'($urandom);
            end
            if (r) k++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) begin
            total++;
            bad++;
            $display("FAIL stream_timeout got=%0d want=%0d", k, N);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("end_done", 32'(done), 32'd1);
        chk("end_err",  32'(err), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_oval", 32'(out_valid), 32'd0);
        chk("end_odat", 32'(out_data), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},  32'(in_ready), 32'd0);
        chk({tag, "_oval"}, 32'(out_valid), 32'd0);
        chk({tag, "_odat"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"},  32'(err), 32'd0);
    endtask

    initial begin
        #2;
        chk_all_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back runs: each start lands in the cycle done is high.
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd10, 8'd20, 8'd30, 8'd40};
        run_op(2'd0, 0);
        va = '{8'd5, 8'd0, 8'd7, 8'd9};
        vb = '{8'd6, 8'd1, 8'd7, 8'd0};
        run_op(2'd1, 0);
        va = '{8'd200, 8'd0, 8'd255, 8'd128};
        vb = '{8'd100, 8'd0, 8'd1, 8'd128};
        run_op(2'd0, 0);
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        run_op(2'd2, 0);
        rand_operands();
        run_op(2'd0, 2);
        rand_operands();
        run_op(2'd1, 2);
        rand_operands();
        run_op(2'd2, 2);
        run_op(2'd3, 0);

        // Reset in the middle of LOAD_B.
        start = 1'b1;
        op    = 2'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N + 1; i++) begin
            in_valid = 1'b1;
            in_data  = LENGTH'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero("inrst");
        end
        rst = 1'b0;
        rand_operands();
        run_op(2'd0, 0);

        for (int n = 0; n < 40; n++) begin
            rand_operands();
            run_op(2'($urandom), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_op_seq.md
MATRIX_OP_SEQ -- requirements
Module: matrix_op_seq

Interface
REQ-001 The block SHALL have parameter SIZE, default 2, matrix dimension (SIZE x SIZE, N = SIZE*SIZE elements).
REQ-002 The block SHALL have parameter LENGTH, default 8, element width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, request to begin an operation.
REQ-006 The block SHALL have port op, input, 2 bits, operation code sampled with start: 0 add, 1 subtract, 2 transpose, 3 illegal.
REQ-007 The block SHALL have port in_data, input, LENGTH bits, operand element, row-major order.
REQ-008 The block SHALL have port in_valid, input, 1 bit, in_data valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit, block accepts in_data.
REQ-010 The block SHALL have port out_data, output, LENGTH bits, result element, row-major order.
REQ-011 The block SHALL have port out_valid, output, 1 bit, out_data valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, consumer accepts out_data.
REQ-013 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-015 The block SHALL have port err, output, 1 bit, one-cycle illegal-op pulse, coincident with done.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, STREAM; an input handshake is in_valid&in_ready, an output handshake is out_valid&out_ready.
REQ-017 In IDLE, start with op in {0,1,2} SHALL latch op and move to LOAD_A next cycle; start with op=3 SHALL pulse done and err for one cycle and remain IDLE.
REQ-018 start outside IDLE SHALL be ignored, and op SHALL be ignored except when sampled with an accepted start.
REQ-019 in_ready SHALL be 1 exactly in LOAD_A and LOAD_B.
REQ-020 Each input handshake SHALL write in_data to the current operand buffer at index idx, and idx SHALL increment by 1.
REQ-021 The handshake at idx=N-1 SHALL clear idx and go to LOAD_B (op 0/1) or STREAM (op 2); in LOAD_B it SHALL go to STREAM.
REQ-022 out_valid SHALL be 1 exactly in STREAM; the first out_valid occurs the cycle after the final input handshake.
REQ-023 For output index k: op0 SHALL give out_data=(A[k]+B[k]) mod 2^LENGTH; op1 SHALL give (A[k]-B[k]) mod 2^LENGTH; op2 SHALL give A[(k mod SIZE)*SIZE + k/SIZE]; carry and borrow are discarded.
REQ-024 While out_valid=1 and out_ready=0, out_data and k SHALL hold stable.
REQ-025 The output handshake at k=N-1 SHALL return the FSM to IDLE and pulse done for one cycle (the first IDLE cycle), err=0.
REQ-026 start asserted in the cycle done is high SHALL be accepted, since the FSM is already in IDLE.
REQ-027 out_data SHALL be 0 whenever out_valid=0.
REQ-028 Throughput SHALL be one element per cycle in each phase under continuous valid/ready.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and clear idx, k and the latched op.
REQ-030 During reset, in_ready, out_valid, out_data, busy, done and err SHALL all be 0; operand buffer contents are not reset.
REQ-031 Reset asserted mid-operation SHALL abandon it silently (no done); a start in the first cycle after rst deasserts SHALL be accepted.

Verification (SIZE=2, LENGTH=8)
REQ-032 Add: op=0, A=1,2,3,4, B=10,20,30,40, out_ready=1 -> out 11,22,33,44 on consecutive cycles, then done=1 for one cycle, err=0.
REQ-033 Wrap: op=1 with A=5,0,7,9 and B=6,1,7,0 -> out 255,255,0,9; op=0 with A[0]=200, B[0]=100 -> out[0]=44.
REQ-034 Transpose: op=2, A=1,2,3,4 -> out 1,3,2,4; in_ready=0 after the 4th accept and no B phase occurs.
REQ-035 Backpressure: out_ready=0 for 3 cycles in STREAM -> out_data constant, no element skipped or repeated; in_valid gaps in LOAD -> idx advances only on handshakes.
REQ-036 Illegal: start with op=3 -> done=1 and err=1 for exactly one cycle, busy and in_ready stay 0.
REQ-037 Reset mid-LOAD_B -> all outputs 0 while rst=1, no done; a new op=0 run then produces correct results.
